// File: rtl/uart_wb_host.sv
// uart_wb_host: Wishbone master that programs a 16550 (uart_top) after reset
// and then bridges a TX/RX byte-stream interface to THR/RBR by polling LSR.
// Optional feature macro: UART_WB_HOST_IRQ_EN (IER=01, LSR polled only when
// int_i or tx_valid_i is high).
module uart_wb_host #(
    parameter logic [15:0] DIVISOR     = 16'd130,
    parameter logic [7:0]  LCR_VAL     = 8'h03,
    parameter logic [7:0]  FCR_VAL     = 8'h07,
    parameter int          ACK_TIMEOUT = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic       int_i,
    output logic       cfg_done_o,
    output logic       err_timeout_o
);

    localparam logic [3:0] CFG_LCR_DLAB = 4'd0;
    localparam logic [3:0] CFG_DL2      = 4'd1;
    localparam logic [3:0] CFG_DL1      = 4'd2;
    localparam logic [3:0] CFG_LCR      = 4'd3;
    localparam logic [3:0] CFG_FCR      = 4'd4;
    localparam logic [3:0] CFG_IER      = 4'd5;
    localparam logic [3:0] POLL_LSR     = 4'd6;
    localparam logic [3:0] RD_RBR       = 4'd7;
    localparam logic [3:0] WR_THR       = 4'd8;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

`ifdef UART_WB_HOST_IRQ_EN
    localparam logic [7:0] IER_VAL = 8'h01;
`else
    localparam logic [7:0] IER_VAL = 8'h00;
`endif

    logic [3:0] state_reg;
    logic [2:0] adr_reg;
    logic [7:0] dat_reg;
    logic       we_reg;
    logic       stb_reg;
    logic [7:0] tmo_cnt_reg;
    logic       retry_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       cfg_done_reg;
    logic       err_reg;

    logic [2:0] issue_adr;
    logic [7:0] issue_dat;
    logic       issue_we;
    logic       issue_en;
    logic       poll_ok;
    logic [3:0] state_next;
    logic       rx_load;
    logic       cfg_finish;

`ifdef UART_WB_HOST_IRQ_EN
    assign poll_ok = int_i | tx_valid_i;
`else
    logic unused_int;
    assign unused_int = int_i;
    assign poll_ok    = 1'b1;
`endif

    // Access to launch for the current state; a cycle with stb low is an issue cycle
    always_comb begin
        issue_adr = 3'd0;
        issue_dat = 8'h00;
        issue_we  = 1'b0;
        case (state_reg)
            CFG_LCR_DLAB: begin issue_adr = 3'd3; issue_dat = 8'h80 | LCR_VAL; issue_we = 1'b1; end
            CFG_DL2:      begin issue_adr = 3'd1; issue_dat = DIVISOR[15:8];   issue_we = 1'b1; end
            CFG_DL1:      begin issue_adr = 3'd0; issue_dat = DIVISOR[7:0];    issue_we = 1'b1; end
            CFG_LCR:      begin issue_adr = 3'd3; issue_dat = LCR_VAL;         issue_we = 1'b1; end
            CFG_FCR:      begin issue_adr = 3'd2; issue_dat = FCR_VAL;         issue_we = 1'b1; end
            CFG_IER:      begin issue_adr = 3'd1; issue_dat = IER_VAL;         issue_we = 1'b1; end
            POLL_LSR:     begin issue_adr = 3'd5; end
            RD_RBR:       begin issue_adr = 3'd0; end
            WR_THR:       begin issue_adr = 3'd0; issue_dat = tx_data_i;       issue_we = 1'b1; end
            default:      begin issue_adr = 3'd0; end
        endcase
        issue_en = !stb_reg && ((state_reg != POLL_LSR) || poll_ok);
    end

    // Successor state taken when the outstanding access is acknowledged
    always_comb begin
        state_next = state_reg;
        rx_load    = 1'b0;
        cfg_finish = 1'b0;
        case (state_reg)
            CFG_LCR_DLAB: state_next = CFG_DL2;
            CFG_DL2:      state_next = CFG_DL1;
            CFG_DL1:      state_next = CFG_LCR;
            CFG_LCR:      state_next = CFG_FCR;
            CFG_FCR:      state_next = CFG_IER;
            CFG_IER:      begin state_next = POLL_LSR; cfg_finish = 1'b1; end
            POLL_LSR: begin
                // RX first, and only if the single-entry buffer has room this cycle
                if (wb_dat_i[0] && (!rx_valid_reg || rx_ready_i))
                    state_next = RD_RBR;
                else if (wb_dat_i[5] && tx_valid_i)
                    state_next = WR_THR;
                else
                    state_next = POLL_LSR;
            end
            RD_RBR:       begin state_next = POLL_LSR; rx_load = 1'b1; end
            WR_THR:       state_next = POLL_LSR;
            default:      state_next = CFG_LCR_DLAB;
        endcase
    end

    // Bus master, timeout/retry, RX buffer and status flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= CFG_LCR_DLAB;
            adr_reg      <= 3'd0;
            dat_reg      <= 8'h00;
            we_reg       <= 1'b0;
            stb_reg      <= 1'b0;
            tmo_cnt_reg  <= 8'd0;
            retry_reg    <= 1'b0;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
            cfg_done_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (rx_valid_reg && rx_ready_i)
                rx_valid_reg <= 1'b0;
            if (!stb_reg) begin
                if (issue_en) begin
                    stb_reg     <= 1'b1;
                    adr_reg     <= issue_adr;
                    we_reg      <= issue_we;
                    tmo_cnt_reg <= 8'd0;
                    // A retry resends the byte already latched
                    if (!retry_reg)
                        dat_reg <= issue_dat;
                end
            end else if (wb_ack_i) begin
                stb_reg   <= 1'b0;
                retry_reg <= 1'b0;
                state_reg <= state_next;
                if (cfg_finish)
                    cfg_done_reg <= 1'b1;
                if (rx_load) begin
                    rx_data_reg  <= wb_dat_i;
                    rx_valid_reg <= 1'b1;
                end
            end else if (tmo_cnt_reg == TMO_LAST) begin
                stb_reg   <= 1'b0;
                retry_reg <= 1'b1;
                err_reg   <= 1'b1;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
            end
        end
    end

    assign wb_adr_o      = adr_reg;
    assign wb_dat_o      = dat_reg;
    assign wb_we_o       = we_reg;
    assign wb_stb_o      = stb_reg;
    assign wb_cyc_o      = stb_reg;
    assign wb_sel_o      = 4'b0001;
    assign tx_ready_o    = (state_reg == WR_THR) && !stb_reg && !retry_reg;
    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign cfg_done_o    = cfg_done_reg;
    assign err_timeout_o = err_reg;

endmodule

// File: tb/tb_uart_wb_host.sv
// tb_uart_wb_host: directed bench for uart_wb_host with a small Wishbone
// slave model that logs every completed access and every abandoned one.
module tb_uart_wb_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0] wb_sel_o;
    logic       ack = 1'b0;
    logic [7:0] sdat = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready = 1'b0;
    logic       int_in = 1'b0;
    logic       cfg_done_o, err_timeout_o;

    logic [7:0] lsr_val = 8'h00;
    logic [7:0] rbr_val = 8'h00;
    int         withhold_target = 0;

    logic [11:0] log_e [0:4095];
    int log_n = 0, drop_cnt = 0, last_drop = 0, run_len = 0, txr_cnt = 0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_wb_host dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(sdat),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(ack),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .int_i(int_in), .cfg_done_o(cfg_done_o), .err_timeout_o(err_timeout_o)
    );

    // Slave: registered ack one cycle after stb; can withhold ack for an adr-1 write
    always @(posedge clk) begin
        ack  <= wb_stb_o && !ack && !(wb_adr_o == 3'd1 && wb_we_o && drop_cnt < withhold_target);
        sdat <= (wb_adr_o == 3'd5) ? lsr_val : rbr_val;
        if (tx_ready_o) txr_cnt <= txr_cnt + 1;
        if (wb_stb_o && ack) begin
            log_e[log_n % 4096] <= {wb_we_o, wb_adr_o, wb_dat_o};
            log_n   <= log_n + 1;
            run_len <= 0;
        end else if (wb_stb_o) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            drop_cnt  <= drop_cnt + 1;
            last_drop <= run_len;
            run_len   <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int count_match(input int from, input int to, input logic [11:0] pat, input logic [11:0] mask);
        int c = 0;
        for (int i = from; i < to; i++)
            if ((log_e[i % 4096] & mask) == (pat & mask)) c++;
        return c;
    endfunction

    logic [11:0] exp_cfg [0:5];
    int b, b2, d0, t0;

    task automatic wait_cfg(input string tag);
        for (int k = 0; k < 300 && !cfg_done_o; k++) @(negedge clk);
        check(tag, cfg_done_o, 1);
    endtask

    initial begin
        exp_cfg[0] = {1'b1, 3'd3, 8'h83};
        exp_cfg[1] = {1'b1, 3'd1, 8'h00};
        exp_cfg[2] = {1'b1, 3'd0, 8'h82};
        exp_cfg[3] = {1'b1, 3'd3, 8'h03};
        exp_cfg[4] = {1'b1, 3'd2, 8'h07};
`ifdef UART_WB_HOST_IRQ_EN
        exp_cfg[5] = {1'b1, 3'd1, 8'h01};
`else
        exp_cfg[5] = {1'b1, 3'd1, 8'h00};
`endif

        // Reset defaults
        repeat (4) @(negedge clk);
        check("rst_stb", wb_stb_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_sel", wb_sel_o, 4'b0001);
        check("rst_bus", {wb_we_o, wb_adr_o, wb_dat_o}, 0);
        check("rst_flags", {cfg_done_o, err_timeout_o, tx_ready_o, rx_valid_o, rx_data_o}, 0);
        $display("txn reset: outputs sampled");

        // Configuration sequence
        b = log_n;
        rst = 1'b0;
        wait_cfg("cfg_done");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cfg_wr%0d", i), log_e[(b + i) % 4096], exp_cfg[i]);
            $display("txn cfg write %0d: %03h", i, log_e[(b + i) % 4096]);
        end
        check("cfg_no_txready", txr_cnt, 0);
        check("cfg_no_err", err_timeout_o, 0);

`ifdef UART_WB_HOST_IRQ_EN
        // No traffic while idle, then a prompt LSR read on interrupt
        b2 = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wb_stb_o) b2++;
        end
        check("irq_idle_stb", b2, 0);
        int_in = 1'b1;
        b2 = 0;
        for (int k = 0; k < 3 && b2 == 0; k++) begin
            @(negedge clk);
            if (wb_stb_o && wb_adr_o == 3'd5 && !wb_we_o) b2 = 1;
        end
        check("irq_lsr_read", b2, 1);
        $display("txn irq: idle then LSR read");
`else
        repeat (10) @(negedge clk);
        check("poll_lsr", count_match(b + 6, log_n, {1'b0, 3'd5, 8'h00}, 12'hF00) > 0, 1);
        $display("txn poll: LSR reads seen");
`endif

        // TX single byte
        t0 = txr_cnt;
        b  = log_n;
        tx_data = 8'hA5; tx_valid = 1'b1; lsr_val = 8'h60;
        for (int k = 0; k < 50 && !tx_ready_o; k++) @(negedge clk);
        check("tx_ready_seen", tx_ready_o, 1);
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'hFF; lsr_val = 8'h00;
        repeat (30) @(negedge clk);
        check("tx_one_pulse", txr_cnt - t0, 1);
        check("tx_write_cnt", count_match(b, log_n, 12'h800, 12'h800), 1);
        check("tx_write_val", count_match(b, log_n, {1'b1, 3'd0, 8'hA5}, 12'hFFF), 1);
        $display("txn tx: A5 written");

        // RX with backpressure
        lsr_val = 8'h61; rbr_val = 8'h3C; rx_ready = 1'b0;
        for (int k = 0; k < 50 && !rx_valid_o; k++) @(negedge clk);
        check("rx_valid", rx_valid_o, 1);
        check("rx_data", rx_data_o, 8'h3C);
        b2 = log_n;
        repeat (40) @(negedge clk);
        check("rx_no_rbr_full", count_match(b2, log_n, {1'b0, 3'd0, 8'h00}, 12'hF00), 0);
        check("rx_hold", {rx_valid_o, rx_data_o}, {1'b1, 8'h3C});
        rbr_val = 8'h5A; rx_ready = 1'b1;
        b2 = log_n;
        for (int k = 0; k < 50 && count_match(b2, log_n, 12'h000, 12'hF00) == 0; k++) @(negedge clk);
        rx_ready = 1'b0; lsr_val = 8'h00;
        check("rx_second", {rx_valid_o, rx_data_o}, {1'b1, 8'h5A});
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_drained", rx_valid_o, 0);
        $display("txn rx: 3C then 5A");

        // Ack timeout on the DL2 write
        rst = 1'b1;
        withhold_target = drop_cnt + 1;
        repeat (4) @(negedge clk);
        d0 = drop_cnt;
        b  = log_n;
        rst = 1'b0;
        wait_cfg("tmo_cfg_done");
        check("tmo_drops", drop_cnt - d0, 1);
        check("tmo_len", last_drop, 8);
        check("tmo_err", err_timeout_o, 1);
        for (int i = 0; i < 6; i++)
            check($sformatf("tmo_wr%0d", i), log_e[(b + i) % 4096], exp_cfg[i]);
        $display("txn timeout: stb held %0d cycles, retried", last_drop);

        // Reset in the middle of a THR write
        int_in = 1'b1;
        lsr_val = 8'h61; rbr_val = 8'h77; rx_ready = 1'b0;
        for (int k = 0; k < 50 && !rx_valid_o; k++) @(negedge clk);
        check("mid_rx_full", rx_valid_o, 1);
        tx_data = 8'hC3; tx_valid = 1'b1;
        b2 = 0;
        for (int k = 0; k < 80 && b2 == 0; k++) begin
            @(negedge clk);
            if (wb_stb_o && wb_we_o && wb_adr_o == 3'd0) b2 = 1;
        end
        check("mid_thr_active", b2, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out", {wb_stb_o, wb_cyc_o, tx_ready_o, rx_valid_o}, 0);
        check("mid_rst_flags", {cfg_done_o, err_timeout_o}, 0);
        tx_valid = 1'b0; lsr_val = 8'h00;
        b = log_n;
        rst = 1'b0;
        for (int k = 0; k < 20 && log_n == b; k++) @(negedge clk);
        check("mid_restart", log_e[b % 4096], {1'b1, 3'd3, 8'h83});
        wait_cfg("mid_cfg_done");
        $display("txn reset-mid: config restarted");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
